// File: rtl/segasys1_hs_sequencer.sv
// Hiscore access sequencer: routes one byte request at a time to main work RAM or the video port.
// Define SEGASYS1_HS_VBLK_EN to also open the access window during vertical blank.
module segasys1_hs_sequencer #(
  parameter int unsigned RD_LAT = 2
) (
  input  logic        CLK48M,
  input  logic        RESET_N,
  input  logic        PAUSE_N,
  input  logic        VBLK,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic        REQ_WE,
  input  logic [15:0] REQ_AD,
  input  logic [7:0]  REQ_DI,
  output logic        RSP_VALID,
  output logic [7:0]  RSP_DO,
  output logic [15:0] MAIN_AD,
  output logic [7:0]  MAIN_DI,
  output logic        MAIN_WE,
  input  logic [7:0]  MAIN_DO,
  output logic [15:0] VID_AD,
  output logic [7:0]  VID_DI,
  output logic        VID_WE,
  input  logic [7:0]  VID_DO,
  output logic        BUSY
);

  typedef enum logic [2:0] {StIdle, StWaitWin, StIssue, StWaitRd, StResp} state_e;

  localparam logic [2:0] RdLat = 3'(RD_LAT);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        we_q, sel_main_q;
  logic [15:0] ad_q;
  logic [7:0]  di_q, rsp_do_q;
  logic        win, accept, capture;

`ifdef SEGASYS1_HS_VBLK_EN
  assign win = ~PAUSE_N | VBLK;
`else
  logic unused_vblk;
  assign unused_vblk = VBLK;
  assign win = ~PAUSE_N;
`endif

  assign accept  = (state_q == StIdle) && REQ_VALID;
  assign capture = (state_q == StWaitRd) && (cnt_q == 3'd1);

  always_ff @(posedge CLK48M or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= StIdle;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle:    if (REQ_VALID) state_d = StWaitWin;
      StWaitWin: if (win) state_d = StIssue;
      StIssue: begin
        if (we_q) begin
          state_d = StResp;
        end else begin
          state_d = StWaitRd;
          cnt_d   = RdLat;
        end
      end
      StWaitRd: begin
        if (cnt_q == 3'd1) state_d = StResp;
        else               cnt_d   = cnt_q - 3'd1;
      end
      StResp:    state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    REQ_READY = 1'b0;
    RSP_VALID = 1'b0;
    MAIN_WE   = 1'b0;
    VID_WE    = 1'b0;
    BUSY      = 1'b1;
    unique case (state_q)
      StIdle: begin
        REQ_READY = 1'b1;
        BUSY      = 1'b0;
      end
      StIssue: begin
        MAIN_WE = we_q & sel_main_q;
        VID_WE  = we_q & ~sel_main_q;
      end
      StResp:  RSP_VALID = 1'b1;
      default: ;
    endcase
  end

  // Request fields stay on the address/data buses until the next accept.
  always_ff @(posedge CLK48M or negedge RESET_N) begin
    if (!RESET_N) begin
      we_q       <= 1'b0;
      sel_main_q <= 1'b0;
      ad_q       <= 16'h0000;
      di_q       <= 8'h00;
    end else if (accept) begin
      we_q       <= REQ_WE;
      sel_main_q <= (REQ_AD[15:12] == 4'hC);
      ad_q       <= REQ_AD;
      di_q       <= REQ_DI;
    end
  end

  always_ff @(posedge CLK48M or negedge RESET_N) begin
    if (!RESET_N) begin
      rsp_do_q <= 8'h00;
    end else if (capture) begin
      rsp_do_q <= sel_main_q ? MAIN_DO : VID_DO;
    end
  end

  assign RSP_DO  = rsp_do_q;
  assign MAIN_AD = ad_q;
  assign MAIN_DI = di_q;
  assign VID_AD  = ad_q;
  assign VID_DI  = di_q;

endmodule

// File: tb/tb_segasys1_hs_sequencer.sv
// Bench for segasys1_hs_sequencer: directed scenarios plus randomized traffic against a
// transaction-level model that checks every output on every cycle.
module tb_segasys1_hs_sequencer;

  localparam int RD_LAT = 3;
`ifdef SEGASYS1_HS_VBLK_EN
  localparam bit VBLK_ON = 1'b1;
`else
  localparam bit VBLK_ON = 1'b0;
`endif

  logic        CLK48M = 1'b0;
  logic        RESET_N, PAUSE_N, VBLK, REQ_VALID, REQ_WE;
  logic [15:0] REQ_AD;
  logic [7:0]  REQ_DI, MAIN_DO, VID_DO;
  logic        REQ_READY, RSP_VALID, MAIN_WE, VID_WE, BUSY;
  logic [7:0]  RSP_DO, MAIN_DI, VID_DI;
  logic [15:0] MAIN_AD, VID_AD;

  int n_pass = 0;
  int n_total = 0;

  segasys1_hs_sequencer #(.RD_LAT(RD_LAT)) dut (
    .CLK48M(CLK48M), .RESET_N(RESET_N), .PAUSE_N(PAUSE_N), .VBLK(VBLK),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WE(REQ_WE), .REQ_AD(REQ_AD),
    .REQ_DI(REQ_DI), .RSP_VALID(RSP_VALID), .RSP_DO(RSP_DO),
    .MAIN_AD(MAIN_AD), .MAIN_DI(MAIN_DI), .MAIN_WE(MAIN_WE), .MAIN_DO(MAIN_DO),
    .VID_AD(VID_AD), .VID_DI(VID_DI), .VID_WE(VID_WE), .VID_DO(VID_DO), .BUSY(BUSY)
  );

  always #5 CLK48M = ~CLK48M;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge CLK48M);
    #1;
  endtask

  // Counts cycles until RSP_VALID is seen (bounded); also reports any write strobe seen.
  task automatic wait_rsp(input int max, output int n, output bit we_seen);
    n = 0;
    we_seen = MAIN_WE | VID_WE;
    while (RSP_VALID !== 1'b1 && n <= max) begin
      tick();
      n++;
      we_seen |= MAIN_WE | VID_WE;
    end
  endtask

  // Transaction model: phase 0 idle, 1 waiting for window, 2 access running with k cycles
  // elapsed since the window was seen (k=0 is the issue cycle).
  int          m_phase = 0;
  int          m_k = 0;
  bit          m_we = 0, m_main = 0;
  logic [15:0] m_ad = '0;
  logic [7:0]  m_di = '0, m_rsp = '0;

  initial begin
    forever begin
      int  last;
      bit  win_now;
      @(negedge CLK48M);
      if (RESET_N !== 1'b1) begin
        m_phase = 0; m_k = 0; m_we = 0; m_main = 0; m_ad = '0; m_di = '0; m_rsp = '0;
      end
      last = m_we ? 1 : RD_LAT + 1;
      check("ctrl {ready,rsp,main_we,vid_we,busy}",
            {REQ_READY, RSP_VALID, MAIN_WE, VID_WE, BUSY},
            {m_phase == 0, m_phase == 2 && m_k == last,
             m_phase == 2 && m_k == 0 && m_we && m_main,
             m_phase == 2 && m_k == 0 && m_we && !m_main, m_phase != 0});
      check("RSP_DO", RSP_DO, m_rsp);
      check("MAIN_AD", MAIN_AD, m_ad);
      check("MAIN_DI", MAIN_DI, m_di);
      check("VID_AD", VID_AD, m_ad);
      check("VID_DI", VID_DI, m_di);
      if (RESET_N === 1'b1) begin
        win_now = !PAUSE_N || (VBLK_ON && VBLK);
        case (m_phase)
          0: if (REQ_VALID) begin
            m_we = REQ_WE; m_ad = REQ_AD; m_di = REQ_DI;
            m_main = (REQ_AD >= 16'hC000) && (REQ_AD <= 16'hCFFF);
            m_phase = 1;
          end
          1: if (win_now) begin m_phase = 2; m_k = 0; end
          default: begin
            if (!m_we && m_k == RD_LAT) m_rsp = m_main ? MAIN_DO : VID_DO;
            if (m_k == last) m_phase = 0;
            else m_k++;
          end
        endcase
      end
    end
  end

  initial begin
    int n;
    bit we_seen, act, busy_all, rsp_seen;
    RESET_N = 0; PAUSE_N = 0; VBLK = 0; REQ_VALID = 0; REQ_WE = 0;
    REQ_AD = '0; REQ_DI = '0; MAIN_DO = '0; VID_DO = '0;
    tick(); tick();
    check("reset ctrl", {REQ_READY, RSP_VALID, MAIN_WE, VID_WE, BUSY}, 5'b10000);
    check("reset RSP_DO/AD/DI", {RSP_DO, MAIN_AD, VID_DI}, 32'h0);
    RESET_N = 1;
    tick();

    // Write 0xA5 to 0xC010, window open.
    REQ_VALID = 1; REQ_WE = 1; REQ_AD = 16'hC010; REQ_DI = 8'hA5;
    tick();
    REQ_VALID = 0;
    check("wr t0 busy/we", {BUSY, MAIN_WE, REQ_READY}, 3'b100);
    tick();
    check("wr t1 main_we", {MAIN_WE, VID_WE, RSP_VALID}, 3'b100);
    check("wr t1 addr/data", {MAIN_AD, MAIN_DI}, 24'hC010A5);
    tick();
    check("wr t2 rsp", {RSP_VALID, MAIN_WE, REQ_READY}, 3'b100);
    tick();
    check("wr t3 ready", {REQ_READY, RSP_VALID, BUSY}, 3'b100);

    // Read 0x8123 from the video port.
    VID_DO = 8'h5C; MAIN_DO = 8'h11;
    REQ_VALID = 1; REQ_WE = 0; REQ_AD = 16'h8123; REQ_DI = 8'h00;
    tick();
    REQ_VALID = 0;
    wait_rsp(20, n, we_seen);
    check("rd latency", n, RD_LAT + 2);
    check("rd data", RSP_DO, 8'h5C);
    check("rd no strobe", we_seen, 0);
    tick();

    // Window closed for 20 cycles, then opened by PAUSE_N.
    PAUSE_N = 1; VBLK = 0;
    REQ_VALID = 1; REQ_WE = 1; REQ_AD = 16'h1234; REQ_DI = 8'h3C;
    tick();
    REQ_VALID = 0;
    act = 0; busy_all = 1;
    repeat (20) begin
      act |= MAIN_WE | VID_WE | RSP_VALID;
      busy_all &= BUSY;
      tick();
    end
    check("closed window idle", {act, busy_all}, 2'b01);
    PAUSE_N = 0;
    tick();
    check("win issue vid_we", {VID_WE, MAIN_WE, VID_AD, VID_DI}, {2'b10, 16'h1234, 8'h3C});
    tick();
    check("win rsp", RSP_VALID, 1);
    tick();

    // VBLK pulse with PAUSE_N high: issues only when the vblank window is built in.
    PAUSE_N = 1;
    REQ_VALID = 1; REQ_WE = 1; REQ_AD = 16'hC020; REQ_DI = 8'h5A;
    tick();
    REQ_VALID = 0;
    tick(); tick();
    VBLK = 1;
    tick();
    VBLK = 0;
    check("vblk issue", MAIN_WE, VBLK_ON);
    PAUSE_N = 0;
    wait_rsp(10, n, we_seen);
    check("vblk rsp latency", n, VBLK_ON ? 1 : 2);
    tick();

    // PAUSE_N rises during WAIT_RD; the read must still complete.
    MAIN_DO = 8'hE7;
    REQ_VALID = 1; REQ_WE = 0; REQ_AD = 16'hC100;
    tick();
    REQ_VALID = 0;
    tick(); tick();
    PAUSE_N = 1;
    wait_rsp(20, n, we_seen);
    check("atomic rd latency", n, RD_LAT);
    check("atomic rd data", RSP_DO, 8'hE7);
    tick();
    PAUSE_N = 0;

    // Reset during the issue cycle of a write.
    REQ_VALID = 1; REQ_WE = 1; REQ_AD = 16'hC030; REQ_DI = 8'h99;
    tick();
    REQ_VALID = 0;
    tick();
    check("pre-reset main_we", MAIN_WE, 1);
    #1 RESET_N = 0;
    #1;
    check("async reset", {MAIN_WE, REQ_READY, BUSY, MAIN_AD}, {3'b010, 16'h0000});
    tick();
    RESET_N = 1;
    rsp_seen = 0;
    repeat (6) begin
      tick();
      rsp_seen |= RSP_VALID;
    end
    check("no rsp after reset", {rsp_seen, REQ_READY}, 2'b01);

    // Randomized traffic, including occasional resets and requests held through RESP.
    repeat (1500) begin
      tick();
      RESET_N   = ($urandom_range(0, 199) != 0);
      PAUSE_N   = ($urandom_range(0, 2) != 0);
      VBLK      = ($urandom_range(0, 3) == 0);
      REQ_VALID = $urandom_range(0, 1);
      REQ_WE    = $urandom_range(0, 1);
      REQ_AD    = $urandom_range(0, 1) ? (16'hC000 | 16'($urandom_range(0, 4095)))
                                       : 16'($urandom);
      REQ_DI    = 8'($urandom);
      MAIN_DO   = 8'($urandom);
      VID_DO    = 8'($urandom);
    end
    tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/segasys1_hs_sequencer.md
# segasys1_hs_sequencer

Hiscore access sequencer for the System 1/2 core. Takes one byte request at a time from the hiscore module and routes it to main work RAM (0xC000–0xCFFF) or to the video RAM port. An access is issued only inside a safe window: CPU paused, or optionally vertical blank. Replaces direct HSAD/HSWE fan-out with a request/response handshake, per-target write strobes and a registered read path.

## Interface
Parameters:
- RD_LAT, 2, cycles from read issue to data capture at the target port; legal range 1–7.

Ports:
- CLK48M  in  1  system clock, 48 MHz; all state on rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- PAUSE_N  in  1  CPU pause, active low; low opens the access window.
- VBLK  in  1  vertical blank from video, active high.
- REQ_VALID  in  1  request present.
- REQ_READY  out  1  sequencer can accept a request.
- REQ_WE  in  1  1 = write, 0 = read.
- REQ_AD  in  16  hiscore address.
- REQ_DI  in  8  write data.
- RSP_VALID  out  1  one-cycle completion pulse, for reads and writes.
- RSP_DO  out  8  read data, valid when RSP_VALID=1 after a read.
- MAIN_AD  out  16  main RAM address.
- MAIN_DI  out  8  main RAM write data.
- MAIN_WE  out  1  main RAM write strobe.
- MAIN_DO  in  8  main RAM read data.
- VID_AD  out  16  video port address.
- VID_DI  out  8  video port write data.
- VID_WE  out  1  video port write strobe.
- VID_DO  in  8  video port read data.
- BUSY  out  1  high in every state except IDLE.

## Operation
- States: IDLE, WAIT_WIN, ISSUE, WAIT_RD, RESP.
- IDLE: REQ_READY=1. When REQ_VALID=1, latch REQ_WE, REQ_AD and REQ_DI, latch target select, go to WAIT_WIN. Target = main when REQ_AD[15:12]==4'hC, otherwise video.
- Window: WIN = ~PAUSE_N, OR VBLK when the macro is enabled.
- WAIT_WIN: stay while WIN=0. Go to ISSUE on the first cycle with WIN=1. No timeout.
- ISSUE: held for one cycle.
  - Write: the selected *_WE=1 for exactly this cycle, then go to RESP.
  - Read: load the latency counter with RD_LAT, then go to WAIT_RD.
- WAIT_RD: decrement the counter each cycle. When the counter reaches 1, capture the selected *_DO into RSP_DO and go to RESP.
- RESP: RSP_VALID=1 for one cycle, then go to IDLE. REQ_READY is 0 in RESP, so there is no same-cycle re-accept.
- Address and data outputs:
  - MAIN_AD/DI and VID_AD/DI both carry the latched address and data from accept until the next accept.
  - Only the strobe is target-gated; the non-selected *_WE stays 0.
- Atomicity: once ISSUE has been entered, loss of WIN does not abort the access. WIN is sampled only in WAIT_WIN.
- RSP_DO changes only on read capture. On writes it holds its previous value.

## Timing
- Reset values: state=IDLE, REQ_READY=1, RSP_VALID=0, RSP_DO=0, MAIN_WE=VID_WE=0, all AD/DI=0, BUSY=0. Reset mid-access: any WE in progress drops asynchronously and the response is lost.
- Write with WIN already high, accept at edge t0:
  - WE high during cycle t1–t2.
  - RSP_VALID high during t2–t3.
  - REQ_READY high again from t3.
- Read with WIN already high:
  - ISSUE in t1–t2.
  - Capture at edge t2+RD_LAT.
  - RSP_VALID high for one cycle immediately after the capture edge.
  - Total latency from accept to RSP_VALID: RD_LAT+2 cycles.
- WIN rising while in WAIT_WIN: ISSUE starts on the following cycle.
- REQ_VALID held high through RESP is not accepted until IDLE.

## Configuration
- SEGASYS1_HS_VBLK_EN defined: WIN = ~PAUSE_N | VBLK, so hiscore accesses also run during vertical blank while the game runs.
- Not defined: WIN = ~PAUSE_N only, and the VBLK input is ignored.

## Test plan
- Write 0xA5 to 0xC010 with PAUSE_N=0 -> MAIN_WE pulses for exactly 1 cycle with MAIN_AD=0xC010 and MAIN_DI=0xA5; VID_WE stays 0; RSP_VALID arrives 2 cycles after accept.
- Read 0x8123 with RD_LAT=3, VID_DO=0x5C, PAUSE_N=0 -> RSP_DO=0x5C with RSP_VALID 5 cycles after accept; MAIN_WE=VID_WE=0 throughout.
- Request with PAUSE_N=1 and VBLK=0 for 20 cycles -> BUSY=1, no WE pulse, no RSP_VALID; drop PAUSE_N -> access completes with the normal latency counted from WIN rising.
- PAUSE_N=1, VBLK pulse: macro defined -> write issues during VBLK; macro undefined -> no issue.
- PAUSE_N goes high during WAIT_RD -> read still completes and RSP_VALID still fires.
- RESET_N asserted during ISSUE of a write -> MAIN_WE=0 immediately, REQ_READY=1, no RSP_VALID after release.
